// File: rtl/if_id_reg_pkg.sv
// Shared constants and the decode-stage register bundle
// for the IF/ID pipeline register.
package if_id_reg_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'd0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg_bj_detect.sv
// Flags branch/jump instructions whose successor
// occupies a delay slot.
module if_id_reg_bj_detect
    import if_id_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_bj
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_mid;

    assign op         = instr[31:26];
    assign fn         = instr[5:0];
    assign unused_mid = ^instr[25:6];

    always_comb begin
        is_bj = 1'b0;
        unique case (op)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                is_bj = 1'b1;
            OP_SPECIAL:
                is_bj = (fn == FN_JR) || (fn == FN_JALR);
            default:
                is_bj = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// Fetch/Decode pipeline register with stall, flush,
// delay-slot tagging, AdEL detection and a stall counter.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             STALL_D,
    input  logic             FLUSH_D,
    input  logic [31:0]      INSTR_F,
    input  logic [31:0]      PCadd4F,
    input  logic [31:0]      PC_F,
    output logic [31:0]      INSTR_D,
    output logic [31:0]      PCadd4D,
    output logic [31:0]      PC_D,
    output logic             BD_D,
    output logic [4:0]       EXC_D,
    output logic             VALID_D,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [32:0] LO_EXT = {1'b0, IM_BASE};
    localparam logic [32:0] HI_EXT = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    if_id_t           st_q;
    if_id_t           st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             d_is_bj;
    logic             bad;
    logic [32:0]      pc_ext;

    if_id_reg_bj_detect u_bj_detect (
        .instr (st_q.instr),
        .is_bj (d_is_bj)
    );

    // 33-bit compare keeps IM_BASE+IM_SIZE from wrapping
    assign pc_ext = {1'b0, PC_F};
    assign bad    = (PC_F[1:0] != 2'b00)
                 || (pc_ext < LO_EXT)
                 || (pc_ext >= HI_EXT);

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (FLUSH_D) begin
            st_d.instr = NOP;
            st_d.pc    = PC_F;
            st_d.pc4   = PCadd4F;
            st_d.bd    = 1'b0;
            st_d.exc   = EXC_NONE;
            st_d.valid = 1'b0;
        end else if (STALL_D) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
            st_d.instr = bad ? NOP : INSTR_F;
            st_d.pc    = PC_F;
            st_d.pc4   = PCadd4F;
            st_d.bd    = st_q.valid && d_is_bj;
            st_d.exc   = bad ? EXC_ADEL : EXC_NONE;
            st_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q.instr <= NOP;
            st_q.pc    <= PC_RESET;
            st_q.pc4   <= PC_RESET + 32'd4;
            st_q.bd    <= 1'b0;
            st_q.exc   <= EXC_NONE;
            st_q.valid <= 1'b0;
            cnt_q      <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign INSTR_D   = st_q.instr;
    assign PCadd4D   = st_q.pc4;
    assign PC_D      = st_q.pc;
    assign BD_D      = st_q.bd;
    assign EXC_D     = st_q.exc;
    assign VALID_D   = st_q.valid;
    assign STALL_CNT = cnt_q;

endmodule
